// File: rtl/cpu_clk_ctrl.sv
// Clock-enable controller for the RV32I core: issues a one-cycle enable pulse at a
// programmable rate, with run/halt/single-step sequencing from board switches.
module cpu_clk_ctrl #(
  parameter int unsigned      CNT_W       = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = 250_000,
  parameter int unsigned      DEB_CYCLES  = 500_000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_halt_req,
  input  logic             i_div_we,
  input  logic [CNT_W-1:0] i_div_val,
  output logic             o_cpu_en,
  output logic [1:0]       o_state,
  output logic             o_halted,
  output logic [31:0]      o_tick_cnt
);

  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } state_t;

  localparam int unsigned      DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES);

  state_t           state;
  logic [1:0]       run_sync;
  logic [1:0]       step_sync;
  logic             run_s;
  logic             step_s;
  logic [DEB_W-1:0] deb_cnt;
  logic             step_evt;
  logic             halt_lock;
  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] div_eff;
  logic [CNT_W-1:0] cnt;
  logic             last;

  assign run_s   = run_sync[1];
  assign step_s  = step_sync[1];
  assign div_eff = (div_reg == '0) ? CNT_W'(1) : div_reg;
  assign last    = (cnt == div_eff - 1'b1);
  assign o_state = state;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      run_sync  <= '0;
      step_sync <= '0;
    end else begin
      run_sync  <= {run_sync[0], i_run};
      step_sync <= {step_sync[0], i_step};
    end
  end

  // Saturating debounce: the event fires only on the count's first arrival at
  // the limit, so a long hold yields a single step.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      deb_cnt  <= '0;
      step_evt <= 1'b0;
    end else if (!step_s) begin
      deb_cnt  <= '0;
      step_evt <= 1'b0;
    end else if (deb_cnt != DEB_MAX) begin
      deb_cnt  <= deb_cnt + 1'b1;
      step_evt <= (deb_cnt == DEB_MAX - 1'b1);
    end else begin
      step_evt <= 1'b0;
    end
  end

  // A core halt latches until the run switch is seen low.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)         halt_lock <= 1'b0;
    else if (i_halt_req) halt_lock <= 1'b1;
    else if (!run_s)     halt_lock <= 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= HALT;
      o_halted   <= 1'b1;
      o_cpu_en   <= 1'b0;
      o_tick_cnt <= '0;
      div_reg    <= DEFAULT_DIV;
      cnt        <= '0;
    end else begin
      o_cpu_en <= 1'b0;
      if (i_div_we) begin
        div_reg <= i_div_val;
        cnt     <= '0;
      end
      case (state)
        HALT: begin
          if (run_s && !halt_lock && !i_halt_req) begin
            state    <= RUN;
            o_halted <= 1'b0;
            cnt      <= '0;
          end else if (step_evt) begin
            state    <= STEP;
            o_halted <= 1'b0;
          end
        end
        RUN: begin
          if (i_halt_req || !run_s) begin
            state    <= HALT;
            o_halted <= 1'b1;
          end else if (!i_div_we) begin
            if (last) begin
              cnt        <= '0;
              o_cpu_en   <= 1'b1;
              o_tick_cnt <= o_tick_cnt + 32'd1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        STEP: begin
          o_cpu_en   <= 1'b1;
          o_tick_cnt <= o_tick_cnt + 32'd1;
          state      <= HALT;
          o_halted   <= 1'b1;
        end
        default: begin
          state    <= HALT;
          o_halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: directed vector table, hand sequences for step/reset
// corners, and randomized traffic against a behavioural model.
module tb_cpu_clk_ctrl;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        run, step, halt, we;
  logic [31:0] val;
  logic        en;
  logic [1:0]  st;
  logic        halted;
  logic [31:0] tick;

  int checks   = 0;
  int failures = 0;

  cpu_clk_ctrl #(.CNT_W(32), .DEFAULT_DIV(32'd4), .DEB_CYCLES(DEB)) dut (
    .i_clk(clk), .i_reset(rst), .i_run(run), .i_step(step), .i_halt_req(halt),
    .i_div_we(we), .i_div_val(val), .o_cpu_en(en), .o_state(st),
    .o_halted(halted), .o_tick_cnt(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic        halt;
    logic        we;
    logic [31:0] val;
    int          cycles;
    logic [1:0]  st;
    logic        en;
    logic [31:0] tick;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(int r, int h, int w, int v, int c, int s, int e, int t);
    vec_t x;
    x.run = r[0]; x.halt = h[0]; x.we = w[0]; x.val = v;
    x.cycles = c; x.st = s[1:0]; x.en = e[0]; x.tick = t;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Behavioural model: run-mode pulses come from the elapsed cycle count since
  // entering RUN (or a divide write) modulo the effective divide.
  bit          m_rp0, m_rp1, m_sp0, m_sp1, m_evt, m_lock, m_en;
  int          m_streak, m_st;
  int unsigned m_div, m_phase;
  logic [31:0] m_tick;

  task automatic model_reset();
    m_rp0 = 0; m_rp1 = 0; m_sp0 = 0; m_sp1 = 0; m_evt = 0; m_lock = 0; m_en = 0;
    m_streak = 0; m_st = 0; m_div = 4; m_phase = 0; m_tick = 0;
  endtask

  task automatic model_step();
    bit rs, ss, nen;
    int nst;
    int unsigned eff;
    rs = m_rp1; ss = m_sp1; nen = 0; nst = m_st;
    eff = (m_div == 0) ? 1 : m_div;
    case (m_st)
      0: if (rs && !m_lock && !halt) begin nst = 1; m_phase = 0; end
         else if (m_evt) nst = 2;
      1: if (halt || !rs) nst = 0;
         else if (we) m_phase = 0;
         else begin
           m_phase++;
           if (m_phase % eff == 0) nen = 1;
         end
      default: begin nen = 1; nst = 0; end
    endcase
    if (we) m_div = val;
    m_lock = halt ? 1'b1 : (rs ? m_lock : 1'b0);
    if (ss) begin
      m_evt = (m_streak == DEB - 1);
      if (m_streak < DEB) m_streak++;
    end else begin
      m_streak = 0; m_evt = 0;
    end
    m_rp1 = m_rp0; m_rp0 = run; m_sp1 = m_sp0; m_sp0 = step;
    m_st = nst; m_en = nen; m_tick += 32'(nen);
  endtask

  initial begin
    int pulses, pulse_k, seen_step;
    logic [1:0] last_st;
    logic [1:0] seq[$];

    rst = 1; run = 1; step = 0; halt = 0; we = 0; val = 0;
    repeat (3) @(negedge clk);
    chk("reset_state", st, 0);
    chk("reset_halted", halted, 1);
    chk("reset_en", en, 0);
    chk("reset_tick", tick, 0);
    rst = 0;

    // run/div/halt-lock/div-zero sequence
    tbl.push_back(mkv(1,0,0,0, 2, 0,0,0));
    tbl.push_back(mkv(1,0,0,0, 1, 1,0,0));
    tbl.push_back(mkv(1,0,0,0, 3, 1,0,0));
    tbl.push_back(mkv(1,0,0,0, 1, 1,1,1));
    tbl.push_back(mkv(1,0,0,0, 1, 1,0,1));
    tbl.push_back(mkv(1,0,0,0,15, 1,1,5));
    tbl.push_back(mkv(1,0,1,8, 1, 1,0,5));
    tbl.push_back(mkv(1,0,0,0, 7, 1,0,5));
    tbl.push_back(mkv(1,1,0,0, 1, 0,0,5));
    tbl.push_back(mkv(1,0,0,0,10, 0,0,5));
    tbl.push_back(mkv(0,0,0,0, 5, 0,0,5));
    tbl.push_back(mkv(1,0,0,0, 2, 0,0,5));
    tbl.push_back(mkv(1,0,0,0, 1, 1,0,5));
    tbl.push_back(mkv(1,0,0,0, 8, 1,1,6));
    tbl.push_back(mkv(1,0,0,0, 5, 1,0,6));
    tbl.push_back(mkv(1,0,1,0, 1, 1,0,6));
    tbl.push_back(mkv(1,0,0,0, 1, 1,1,7));
    tbl.push_back(mkv(1,0,0,0, 3, 1,1,10));
    foreach (tbl[i]) begin
      run = tbl[i].run; halt = tbl[i].halt; we = tbl[i].we; val = tbl[i].val;
      repeat (tbl[i].cycles) @(negedge clk);
      chk($sformatf("vec%0d_state", i), st, tbl[i].st);
      chk($sformatf("vec%0d_en", i), en, tbl[i].en);
      chk($sformatf("vec%0d_tick", i), tick, tbl[i].tick);
    end
    halt = 0; we = 0;

    // async reset mid-run at counter=2 with div=8
    we = 1; val = 8;
    @(negedge clk);
    we = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    chk("rst_mid_en", en, 0);
    chk("rst_mid_state", st, 0);
    chk("rst_mid_halted", halted, 1);
    chk("rst_mid_tick", tick, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_rel_en", en, 0);
    chk("rst_rel_state", st, 0);
    repeat (2) @(negedge clk);
    chk("rst_rel_run", st, 1);
    repeat (3) @(negedge clk);
    chk("rst_div_default_nopulse", en, 0);
    @(negedge clk);
    chk("rst_div_default_pulse", en, 1);
    chk("rst_div_default_tick", tick, 1);

    // bouncing step press in HALT
    run = 0;
    repeat (4) @(negedge clk);
    chk("step_pre_halt", st, 0);
    step = 1; @(negedge clk);
    step = 0; @(negedge clk);
    step = 1; @(negedge clk);
    step = 0; @(negedge clk);
    step = 1;
    pulses = 0; pulse_k = 0; last_st = 2'd0; seq.delete();
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (en) begin pulses++; pulse_k = k; end
      if (st != last_st) begin seq.push_back(st); last_st = st; end
    end
    chk("step_pulses", pulses, 1);
    chk("step_latency", pulse_k, 8);
    chk("step_tick", tick, 2);
    chk("step_seq_len", seq.size(), 2);
    if (seq.size() == 2) begin
      chk("step_seq0", seq[0], 2);
      chk("step_seq1", seq[1], 0);
    end
    step = 0;
    repeat (6) @(negedge clk);

    // step event coinciding with run_s rising: RUN wins
    step = 1;
    repeat (4) @(negedge clk);
    run = 1;
    seen_step = 0; pulse_k = 0;
    for (int k = 5; k <= 12; k++) begin
      @(negedge clk);
      if (st == 2'd2) seen_step++;
      if (k == 6) chk("coinc_halt_k6", st, 0);
      if (k == 7) chk("coinc_run_k7", st, 1);
      if (en && pulse_k == 0) pulse_k = k;
    end
    chk("coinc_no_step", seen_step, 0);
    chk("coinc_first_pulse", pulse_k, 11);
    chk("coinc_tick", tick, 3);
    step = 0;

    // randomized traffic against the model
    rst = 1; run = 0; halt = 0; we = 0; val = 0;
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      checks++;
      if (en !== m_en || st !== 2'(m_st) || tick !== m_tick || halted !== (m_st == 0)) begin
        failures++;
        $display("FAIL rand cyc=%0d en=%0b/%0b state=%0d/%0d tick=%0d/%0d halted=%0b",
                 c, en, m_en, st, m_st, tick, m_tick, halted);
      end
      if ($urandom_range(15) == 0) run = ~run;
      if ($urandom_range(9) == 0) step = ~step;
      halt = ($urandom_range(29) == 0);
      we   = ($urandom_range(39) == 0);
      val  = $urandom_range(6);
      model_step();
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
